// File: rtl/ss_serial_loader_if.sv
// Bundles the serial pins and the register-bank write port of ss_serial_loader.
// The slave side is the loader; the master side is whatever drives the pins and consumes writes.
interface ss_serial_loader_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              ena;
    logic              ser_clk;
    logic              ser_data;
    logic              ser_latch;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              frame_err;
    logic [7:0]        frame_cnt;

    modport master (
        output ena,
        output ser_clk,
        output ser_data,
        output ser_latch,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  busy,
        input  frame_err,
        input  frame_cnt
    );

    modport slave (
        input  ena,
        input  ser_clk,
        input  ser_data,
        input  ser_latch,
        output wr_en,
        output wr_addr,
        output wr_data,
        output busy,
        output frame_err,
        output frame_cnt
    );
endinterface

// File: rtl/ss_serial_loader.sv
// Serial address/data frame loader: synchronises three slow pins, deserialises MSB-first
// frames and issues a one-cycle write strobe; malformed frames are dropped and flagged.
module ss_serial_loader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ss_serial_loader_if.slave  bus
);
    localparam int FRAME_LEN = ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_LEN + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Pin order in the synchroniser bank: 0 = ser_clk, 1 = ser_data, 2 = ser_latch.
    logic [2:0] w_pins;
    logic [2:0] w_sync;

    assign w_pins = {bus.ser_latch, bus.ser_data, bus.ser_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic r_s1;
            logic r_s2;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= w_pins[gi];
                    r_s2 <= r_s1;
                end
            end
            assign w_sync[gi] = r_s2;
        end
    endgenerate

    logic w_clk_s;
    logic w_data_s;
    logic w_latch_s;
    logic r_clk_d;
    logic r_latch_d;
    logic w_clk_rise;
    logic w_latch_rise;

    assign w_clk_s      = w_sync[0];
    assign w_data_s     = w_sync[1];
    assign w_latch_s    = w_sync[2];
    assign w_clk_rise   = w_clk_s & ~r_clk_d;
    assign w_latch_rise = w_latch_s & ~r_latch_d;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_shift;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [FRAME_LEN-1:0] r_sr;
    logic [FRAME_LEN-1:0] w_sr_shift;
    logic                 w_has_bits;
    logic                 w_commit;
    logic                 w_reject;

    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;
    logic                 r_busy;
    logic                 r_frame_err;
    logic [7:0]           r_frame_cnt;

    // A same-cycle bit and latch are resolved by shifting first, so the latch
    // decision always sees the post-shift count and shift register.
    always_comb begin
        w_sr_shift   = w_clk_rise ? {r_sr[FRAME_LEN-2:0], w_data_s} : r_sr;
        w_cnt_shift  = (w_clk_rise && (r_cnt != CNT_OVF)) ? r_cnt + 1'b1 : r_cnt;
        w_has_bits   = (r_state == S_SHIFT) || w_clk_rise;
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_commit     = 1'b0;
        w_reject     = 1'b0;
        if (bus.ena && w_has_bits) begin
            if (w_latch_rise) begin
                if (w_cnt_shift == CNT_FULL) begin
                    w_commit     = 1'b1;
                    w_state_next = S_COMMIT;
                end else begin
                    w_reject     = 1'b1;
                end
            end else begin
                w_state_next = S_SHIFT;
                w_cnt_next   = w_cnt_shift;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_d     <= 1'b0;
            r_latch_d   <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_clk_d   <= w_clk_s;
            r_latch_d <= w_latch_s;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_busy    <= (w_state_next == S_SHIFT);
            r_wr_en   <= w_commit;
            if (bus.ena) begin
                r_sr <= w_sr_shift;
            end
            if (w_commit) begin
                r_wr_addr   <= w_sr_shift[FRAME_LEN-1 -: ADDR_W];
                r_wr_data   <= w_sr_shift[DATA_W-1:0];
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_frame_err <= 1'b0;
            end else if (w_reject) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = r_busy;
    assign bus.frame_err = r_frame_err;
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_ss_serial_loader.sv
// Bench for ss_serial_loader: directed frames through the serial pins, a frame-level
// model checked every cycle, and literal expectations at the end of each scenario.
module tb_ss_serial_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ss_serial_loader_if #(.ADDR_W(3), .DATA_W(8)) bus ();
    ss_serial_loader #(.ADDR_W(3), .DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int edge_no;
        bit is_latch;
        bit b;
    } ev_t;
    ev_t evq[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit rst_at_edge = 1'b0;
    bit ena_at_edge = 1'b1;

    // Frame-level model state
    int m_frame = 0;
    int m_bits = 0;
    int m_cnt = 0;
    int m_addr = 0;
    int m_data = 0;
    bit m_wr = 0;
    bit m_err = 0;
    bit m_valid = 0;

    int wr_pulses = 0;
    int last_wr_cyc = 0;
    int latch_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_at_edge = rst_n;
        ena_at_edge = bus.ena;
    end

    // A pin rise driven just after edge c acts at edge c+3.
    always @(negedge clk) begin : p_model
        ev_t e;
        logic [21:0] exp_v;
        logic [21:0] act_v;
        m_wr = 1'b0;
        if (!rst_at_edge) begin
            m_frame = 0; m_bits = 0; m_cnt = 0; m_addr = 0; m_data = 0; m_err = 0;
            m_valid = 1'b1;
            while (evq.size() > 0 && evq[0].edge_no <= cyc) void'(evq.pop_front());
        end else begin
            while (evq.size() > 0 && evq[0].edge_no <= cyc) begin
                e = evq.pop_front();
                if (ena_at_edge) begin
                    if (!e.is_latch) begin
                        m_frame = ((m_frame << 1) | int'(e.b)) & 'h7FF;
                        m_bits  = (m_bits >= 12) ? 12 : m_bits + 1;
                    end else if (m_bits != 0) begin
                        if (m_bits == 11) begin
                            m_wr   = 1'b1;
                            m_addr = m_frame / 256;
                            m_data = m_frame % 256;
                            m_cnt  = (m_cnt + 1) % 256;
                            m_err  = 1'b0;
                        end else begin
                            m_err = 1'b1;
                        end
                        m_bits = 0;
                    end
                end
            end
            if (!ena_at_edge) m_bits = 0;
        end
        if (m_valid) begin
            exp_v = {m_wr, (m_bits != 0), m_err, 8'(m_cnt), 3'(m_addr), 8'(m_data)};
            act_v = {bus.wr_en, bus.busy, bus.frame_err, bus.frame_cnt, bus.wr_addr, bus.wr_data};
            check("cycle_outputs", 32'(act_v), 32'(exp_v));
        end
        if (bus.wr_en === 1'b1) begin
            wr_pulses++;
            last_wr_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_latch, input bit b);
        ev_t e;
        e.edge_no = cyc + 3;
        e.is_latch = is_latch;
        e.b = b;
        evq.push_back(e);
    endtask

    task automatic send_bit(input bit b);
        bus.ser_data = b;
        tick(3);
        bus.ser_clk = 1'b1;
        push(1'b0, b);
        tick(3);
        bus.ser_clk = 1'b0;
    endtask

    task automatic send_latch();
        tick(3);
        bus.ser_latch = 1'b1;
        push(1'b1, 1'b0);
        latch_cyc = cyc;
        tick(3);
        bus.ser_latch = 1'b0;
        tick(3);
    endtask

    task automatic send_bits(input int n, input logic [15:0] pattern);
        for (int i = n - 1; i >= 0; i--) send_bit(pattern[i]);
    endtask

    task automatic send_frame(input logic [2:0] a, input logic [7:0] d);
        logic [10:0] f;
        f = {a, d};
        for (int i = 10; i >= 0; i--) send_bit(f[i]);
        send_latch();
    endtask

    // Last bit and latch rise on the very same clk edge.
    task automatic send_frame_sim(input logic [2:0] a, input logic [7:0] d);
        logic [10:0] f;
        f = {a, d};
        for (int i = 10; i >= 1; i--) send_bit(f[i]);
        bus.ser_data = f[0];
        tick(3);
        bus.ser_clk = 1'b1;
        bus.ser_latch = 1'b1;
        push(1'b0, f[0]);
        push(1'b1, 1'b0);
        latch_cyc = cyc;
        tick(3);
        bus.ser_clk = 1'b0;
        bus.ser_latch = 1'b0;
        tick(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        logic [7:0] ib;
        bus.ena = 1'b1;
        bus.ser_clk = 1'b0;
        bus.ser_data = 1'b0;
        bus.ser_latch = 1'b0;

        // 1: reset with pins toggling, then reset mid-frame
        tick(1);
        bus.ser_clk = 1'b1; bus.ser_data = 1'b1; bus.ser_latch = 1'b1;
        tick(1);
        bus.ser_clk = 1'b0; bus.ser_latch = 1'b0;
        tick(1);
        bus.ser_clk = 1'b1;
        tick(1);
        bus.ser_clk = 1'b0; bus.ser_data = 1'b0;
        tick(3);
        check("reset_outputs", {10'd0, bus.wr_en, bus.busy, bus.frame_err, bus.frame_cnt,
                                bus.wr_addr, bus.wr_data}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        p0 = wr_pulses;
        send_bits(5, 16'b10110);
        tick(1);
        check("busy_mid_frame", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick(2);
        check("busy_after_reset", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("no_write_on_reset", 32'(wr_pulses - p0), 32'd0);

        // 2: good frame
        p0 = wr_pulses;
        send_frame(3'b101, 8'hA5);
        check("good_pulses", 32'(wr_pulses - p0), 32'd1);
        check("good_latency", 32'(last_wr_cyc - latch_cyc), 32'd3);
        check("good_addr", 32'(bus.wr_addr), 32'd5);
        check("good_data", 32'(bus.wr_data), 32'hA5);
        check("good_cnt", 32'(bus.frame_cnt), 32'd1);
        check("good_err", 32'(bus.frame_err), 32'd0);

        // 3: short frame, then recovery
        p0 = wr_pulses;
        send_bits(10, 16'h02AA);
        send_latch();
        check("short_pulses", 32'(wr_pulses - p0), 32'd0);
        check("short_err", 32'(bus.frame_err), 32'd1);
        p0 = wr_pulses;
        send_frame(3'b000, 8'h3C);
        check("recover_pulses", 32'(wr_pulses - p0), 32'd1);
        check("recover_data", 32'(bus.wr_data), 32'h3C);
        check("recover_addr", 32'(bus.wr_addr), 32'd0);
        check("recover_err", 32'(bus.frame_err), 32'd0);

        // 4: overflow frame, then an empty latch
        p0 = wr_pulses;
        send_bits(13, 16'h1FFF);
        send_latch();
        check("ovf_pulses", 32'(wr_pulses - p0), 32'd0);
        check("ovf_err", 32'(bus.frame_err), 32'd1);
        send_latch();
        check("empty_pulses", 32'(wr_pulses - p0), 32'd0);
        check("empty_err", 32'(bus.frame_err), 32'd1);
        check("ovf_cnt", 32'(bus.frame_cnt), 32'd2);

        // 5: 11th bit and latch together
        p0 = wr_pulses;
        send_frame_sim(3'b110, 8'h81);
        check("sim_pulses", 32'(wr_pulses - p0), 32'd1);
        check("sim_addr", 32'(bus.wr_addr), 32'd6);
        check("sim_data", 32'(bus.wr_data), 32'h81);
        check("sim_cnt", 32'(bus.frame_cnt), 32'd3);

        // 6: ena abort, then full frame
        p0 = wr_pulses;
        send_bits(6, 16'h003F);
        bus.ena = 1'b0;
        tick(3);
        check("ena_busy", 32'(bus.busy), 32'd0);
        bus.ena = 1'b1;
        tick(3);
        send_frame(3'b010, 8'h5E);
        check("ena_pulses", 32'(wr_pulses - p0), 32'd1);
        check("ena_addr", 32'(bus.wr_addr), 32'd2);
        check("ena_data", 32'(bus.wr_data), 32'h5E);

        // 6b: counter wrap after 256 frames from reset
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("wrap_start", 32'(bus.frame_cnt), 32'd0);
        p0 = wr_pulses;
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            send_frame(ib[2:0], ib ^ 8'h96);
        end
        check("wrap_pulses", 32'(wr_pulses - p0), 32'd256);
        check("wrap_cnt", 32'(bus.frame_cnt), 32'd0);
        check("wrap_last_data", 32'(bus.wr_data), 32'h69);
        check("wrap_last_addr", 32'(bus.wr_addr), 32'd7);
        check("queue_drained", 32'(evq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
